// File: rtl/dr_pkg.sv
// rtl/dr_pkg.sv - shared types and constants for dual-rail capture stages
package dr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRECH = 3'd1,
        ST_EVAL  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } dr_state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;
    localparam logic [1:0] FC_PARITY  = 2'b11;

    // Rail codes as {t, f}
    localparam logic [1:0] RAIL_SPACER  = 2'b00;
    localparam logic [1:0] RAIL_ONE     = 2'b10;
    localparam logic [1:0] RAIL_ZERO    = 2'b01;
    localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

    // Data-integrity faults (as opposed to timing faults)
    function automatic logic fc_is_data_error(input logic [1:0] fc);
        return (fc == FC_ILLEGAL) || (fc == FC_PARITY);
    endfunction

endpackage

// File: rtl/dr_capture_stage_if.sv
// rtl/dr_capture_stage_if.sv - captured-word valid/ready handshake
interface dr_capture_stage_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/dr_completion_detect.sv
// rtl/dr_completion_detect.sv - dual-rail word complete/spacer/illegal reduction
module dr_completion_detect
    import dr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_t,
    input  logic [WIDTH-1:0] in_f,
    output logic             complete,
    output logic             spacer,
    output logic             illegal
);

    // Per-bit rail classification folded into word-level flags
    always_comb begin
        complete = 1'b1;
        spacer   = 1'b1;
        illegal  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (({in_t[i], in_f[i]} != RAIL_ONE) && ({in_t[i], in_f[i]} != RAIL_ZERO))
                complete = 1'b0;
            if ({in_t[i], in_f[i]} != RAIL_SPACER)
                spacer = 1'b0;
            if ({in_t[i], in_f[i]} == RAIL_ILLEGAL)
                illegal = 1'b1;
        end
    end

endmodule

// File: rtl/dr_capture_stage.sv
// rtl/dr_capture_stage.sv - dual-rail precharge/evaluate capture stage (optional DR_PARITY_EN)
module dr_capture_stage
    import dr_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PRE_CYCLES   = 1,
    parameter int EVAL_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_t,
    input  logic [WIDTH-1:0] in_f,
`ifdef DR_PARITY_EN
    input  logic             in_par_t,
    input  logic             in_par_f,
`endif
    input  logic             start,
    input  logic             clear_fault,
    output logic             precharge,
    dr_capture_stage_if.master out_if,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int CW = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;
    localparam int TW = (EVAL_TIMEOUT > 1) ? $clog2(EVAL_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(PRE_CYCLES - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(EVAL_TIMEOUT - 1);

    dr_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    fc_d;
    logic          capture;
    logic          w_complete, w_spacer, w_illegal;

`ifdef DR_PARITY_EN
    dr_completion_detect #(.WIDTH(WIDTH + 1)) u_detect (
        .in_t     ({in_par_t, in_t}),
        .in_f     ({in_par_f, in_f}),
        .complete (w_complete),
        .spacer   (w_spacer),
        .illegal  (w_illegal)
    );
`else
    dr_completion_detect #(.WIDTH(WIDTH)) u_detect (
        .in_t     (in_t),
        .in_f     (in_f),
        .complete (w_complete),
        .spacer   (w_spacer),
        .illegal  (w_illegal)
    );
`endif

    // Next-state, counters and fault code for the precharge/evaluate sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        fc_d    = fault_code;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PRECH;
                    cnt_d   = CNT_LOAD;
                    tcnt_d  = '0;
                end
            end
            ST_PRECH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (w_spacer) begin
                    state_d = ST_EVAL;
                    tcnt_d  = '0;
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_TIMEOUT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_EVAL: begin
                if (w_illegal) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_ILLEGAL;
                end else if (w_complete) begin
`ifdef DR_PARITY_EN
                    if ((^in_t) != in_par_t) begin
                        state_d = ST_FAULT;
                        fc_d    = FC_PARITY;
                    end else begin
                        state_d = ST_HOLD;
                        capture = 1'b1;
                    end
`else
                    state_d = ST_HOLD;
                    capture = 1'b1;
`endif
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_TIMEOUT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_if.out_ready)
                    state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    state_d = ST_IDLE;
                    fc_d    = FC_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and all outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            tcnt_q           <= '0;
            precharge        <= 1'b1;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            busy             <= 1'b0;
            fault            <= 1'b0;
            fault_code       <= FC_NONE;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            tcnt_q           <= tcnt_d;
            precharge        <= (state_d != ST_EVAL);
            out_if.out_valid <= (state_d == ST_HOLD);
            busy             <= (state_d != ST_IDLE);
            fault            <= (state_d == ST_FAULT);
            fault_code       <= fc_d;
            if (capture)
                out_if.out_data <= in_t;
        end
    end

endmodule

// File: doc/dr_capture_stage.md
Name: dr_capture_stage

Overview:
- Downstream stage of the dual-rail (true/false rail) XOR network in the AES datapath.
- Drives the precharge/evaluate phase of the upstream network.
- Detects completion of a WIDTH-bit dual-rail word, checks it for illegal codes, and captures it as single-rail data.
- Hands the data on through a valid/ready handshake; illegal codes and evaluation timeouts raise a sticky fault.

Parameters:
- WIDTH, 8, number of dual-rail bits captured.
- PRE_CYCLES, 1, minimum cycles precharge is held before evaluation (>=1).
- EVAL_TIMEOUT, 15, max cycles waited in EVAL for completion, and in PRECH for spacer, before faulting (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_t  in  WIDTH  true rails from the XOR network.
- in_f  in  WIDTH  false rails from the XOR network.
- start  in  1  level request for a new evaluation; sampled only in IDLE.
- clear_fault  in  1  leaves FAULT; ignored elsewhere.
- precharge  out  1  1 = upstream forced to spacer (all rails 0); 0 = evaluate.
- out_data  out  WIDTH  captured true rails.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  state != IDLE.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 illegal (both rails 1), 10 timeout, 11 parity error.

Behaviour:
- Rail code per bit (t,f):
  - 00 = spacer.
  - 10 = logic 1, 01 = logic 0.
  - 11 = illegal.
  - Word complete = every bit 10 or 01. Word spacer = every bit 00.
- Reset: state IDLE, precharge=1, out_valid=0, out_data=0, fault=0, fault_code=00, counters 0.
- All outputs are registered.
- IDLE:
  - precharge=1.
  - start=1 -> PRECH; cnt loaded with PRE_CYCLES-1; timeout counter cleared.
- PRECH:
  - precharge=1; cnt decrements to 0.
  - When cnt==0 and word spacer sampled -> EVAL; timeout counter cleared.
  - When cnt==0 and not spacer, the timeout counter increments. Reaching EVAL_TIMEOUT -> FAULT, code 10.
- EVAL:
  - precharge=0.
  - Each cycle, checks are applied in this priority order:
    - (1) any bit 11 -> FAULT, code 01.
    - (2) word complete -> out_data<=in_t, out_valid<=1 -> HOLD.
    - (3) otherwise timeout counter increments; reaching EVAL_TIMEOUT -> FAULT, code 10.
  - Partially complete words with no illegal bit are not errors.
- HOLD:
  - precharge=1; out_valid=1; out_data stable.
  - out_ready=1 -> out_valid<=0 -> IDLE.
  - start is ignored in HOLD. A start held high through the out_ready cycle is accepted in the following IDLE cycle.
- FAULT:
  - precharge=1, out_valid=0, fault=1, fault_code held.
  - clear_fault=1 -> fault<=0, code<=00 -> IDLE.
- Latency: start sampled at edge k, spacer present, complete word present in first EVAL cycle -> out_valid=1 after edge k+PRE_CYCLES+1.
- Throughput: one word per PRE_CYCLES+3 cycles when out_ready is held high.
- rst mid-operation returns every register to its reset value on that edge and discards any captured word.
- in_t and in_f are sampled directly from the XOR network. Rail timing is the network's responsibility; the stage only registers outputs.

Optional Feature:
- Macro: DR_PARITY_EN.
- When defined:
  - Adds ports in_par_t / in_par_f (in, 1), a dual-rail even-parity bit covering the word.
  - The parity bit is included in the spacer, complete and illegal checks.
  - In EVAL on completion, if XOR-reduce(in_t) != in_par_t -> FAULT, code 11, and out_valid stays 0.
- When undefined: the ports are absent and code 11 is never produced.

Decomposition:
- Package dr_pkg holds:
  - State enum (IDLE, PRECH, EVAL, HOLD, FAULT).
  - fault_code constants FC_NONE/FC_ILLEGAL/FC_TIMEOUT/FC_PARITY.
  - Rail-code localparams.
- Sub-module dr_completion_detect: combinational reduction of (in_t, in_f) to complete/spacer/illegal flags, parameterised by WIDTH. Reused by other dual-rail stages.

Test Plan:
- Normal capture: WIDTH=8, PRE_CYCLES=1; rst, start=1, rails 00 in PRECH, then in_t=8'hA5, in_f=8'h5A with out_ready=1 -> precharge falls for one cycle, out_data=8'hA5, out_valid high exactly one cycle, return to IDLE.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid and out_data=8'h3C held stable, precharge=1; out_ready=1 -> IDLE next edge.
- Illegal code: bit 3 driven 11 during EVAL -> fault=1, code 01, out_valid=0; start ignored; clear_fault -> IDLE, code 00.
- Timeout: bit 0 held 00 in EVAL, others valid -> fault code 10 after exactly EVAL_TIMEOUT EVAL cycles. Separately, non-spacer rails held in PRECH -> code 10.
- Reset mid-EVAL: rst asserted during EVAL with complete word -> next cycle precharge=1, out_valid=0, out_data=0, busy=0.
- DR_PARITY_EN: word 8'h07 with parity rail 0 -> code 11. Word 8'h07 with parity rail 1 -> normal capture.
